pwm_sample_feeder: RTL and testbench
====================================

Name: pwm_sample_feeder

Overview:
- Upstream stage of the pwm block: buffers signed audio samples from the sample source and converts each to an unsigned 8-bit duty cycle.
- Releases exactly one duty value per PWM frame (FRAME_LEN clocks) on data_out/valid_data_out, which drive the pwm block's data_in/valid_data_in.
- Absorbs source burstiness with a small FIFO, primes before playback, and substitutes midscale silence on underrun.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- FRAME_LEN, 256, clocks per PWM frame; matches the pwm counter period + 1.
- PRIME_LEVEL, 8, FIFO fill required before playback starts; 1..DEPTH.
- IN_W, 16, input sample width, signed two's complement, >= 8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  playback enable.
- s_data  in  IN_W  signed input sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  feeder can accept s_data this cycle.
- data_out  out  32  duty value to pwm; bits [7:0] carry the duty, bits [31:8] are 0.
- valid_data_out  out  1  one-cycle strobe, data_out valid.
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy.
- underrun_count  out  16  count of frames served with silence; saturates.
- running  out  1  high in RUN state.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, FIFO empty, fill=0, frame counter=0.
  - data_out=0, valid_data_out=0, underrun_count=0, running=0, s_ready=0.
- Accept: a push occurs when s_valid && s_ready.
  - s_ready = (state != IDLE) && (fill < DEPTH).
  - s_ready depends only on registered state, never on s_valid.
  - s_data is ignored when not accepted.
- Conversion: duty = {~s[IN_W-1], s[IN_W-2:IN_W-8]}, i.e. the top 8 bits with the MSB inverted.
  - Examples: 0x8000 -> 0x00, 0x0000 -> 0x80, 0x7FFF -> 0xFF.
  - The pop path applies the conversion. The FIFO stores raw samples.
- State machine:
  - IDLE: when enable=1, go to PRIME next cycle.
  - PRIME: accept samples. When fill >= PRIME_LEVEL (including pushes committed on earlier edges), go to RUN next cycle with the frame counter at 0.
  - RUN: the frame counter counts 0..FRAME_LEN-1 and wraps. A tick is the cycle with counter == FRAME_LEN-1.
  - Any state: enable=0 forces IDLE on the next edge. The FIFO is flushed (fill=0), the frame counter is cleared, and no strobe is emitted. underrun_count is retained.
- Tick in RUN, FIFO non-empty:
  - Pop the head.
  - On the next cycle: data_out = converted duty, valid_data_out=1 for exactly that one cycle.
  - Latency from tick to strobe is 1 clock.
- Tick in RUN, FIFO empty:
  - Strobe as above with data_out=0x80.
  - underrun_count increments, saturating at 0xFFFF.
  - State stays RUN; no re-prime.
- A push and a pop in the same cycle both take effect, so fill is unchanged.
  - A push into an empty FIFO on the tick cycle does not bypass; that frame counts as an underrun.
- When full (fill==DEPTH), s_ready=0. A simultaneous pop does not re-enable s_ready until the next cycle.
- data_out holds its last value between strobes. Consecutive strobes are exactly FRAME_LEN clocks apart while in RUN.
- Reset asserted mid-frame or mid-push: the reset values above apply on that edge, and the pending strobe is cancelled.

Test Plan:
- Reset, enable=1, push 8 samples 0x0000 back-to-back -> running rises 1 cycle after the 8th push. The first strobe comes 256 clocks after entering RUN with data_out=0x00000080, then the next strobe 256 clocks later.
- Push 0x8000, 0x7FFF, 0x1234, 0xFF00 (then prime-fill with 0s) -> strobes in order give data_out 0x00, 0xFF, 0x92, 0x7F; fill decrements by 1 per strobe.
- Push 16 samples with s_valid held high -> fill=16, s_ready=0, the 17th sample is not accepted. After the next tick, s_ready=1 one cycle after the pop.
- Prime 8 samples, stop the source -> 8 data strobes, then strobes of 0x80 every 256 clocks. underrun_count reads 1, 2, 3...; force its value to 0xFFFF and confirm it stays at 0xFFFF.
- Deassert enable mid-frame in RUN with fill=5 -> next cycle state=IDLE, fill=0, running=0, s_ready=0, no further strobes. Re-enable -> PRIME, and playback restarts only after 8 new pushes.
- Pulse rst_n=0 for one cycle on the cycle before a tick -> no strobe, all outputs take their reset values, the FIFO is empty.

Source files
------------

// File: rtl/pwm_sample_feeder.sv
// rtl/pwm_sample_feeder.sv - buffers signed samples and releases one 8-bit duty value per PWM frame
module pwm_sample_feeder #(
    parameter int DEPTH       = 16,
    parameter int FRAME_LEN   = 256,
    parameter int PRIME_LEVEL = 8,
    parameter int IN_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [IN_W-1:0]        s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [31:0]            data_out,
    output logic                   valid_data_out,
    output logic [$clog2(DEPTH):0] fill,
    output logic [15:0]            underrun_count,
    output logic                   running
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t          state, state_nxt;
    logic [IN_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   frame_cnt;
    logic [IN_W-1:0] head;
    logic [7:0]      head_duty;
    logic            push, pop, tick;

    assign s_ready   = (state != IDLE) && (fill < (AW+1)'(DEPTH));
    assign running   = (state == RUN);
    assign tick      = running && enable && (frame_cnt == CW'(FRAME_LEN - 1));
    assign push      = s_valid && s_ready && enable;
    assign pop       = tick && (fill != '0);
    assign head      = mem[rd_ptr];
    // Offset-binary: inverting the sign bit maps the signed range onto 0..255.
    assign head_duty = {~head[IN_W-1], head[IN_W-2:IN_W-8]};

    generate
        if (IN_W > 8) begin : g_low_bits
            logic unused_low_bits;
            assign unused_low_bits = ^head[IN_W-9:0];
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = PRIME;
            PRIME:   if (fill >= (AW+1)'(PRIME_LEVEL)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        if (!enable) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill           <= '0;
            frame_cnt      <= '0;
            data_out       <= '0;
            valid_data_out <= 1'b0;
            underrun_count <= '0;
        end else begin
            state <= state_nxt;
            if (!enable) begin
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                fill           <= '0;
                frame_cnt      <= '0;
                valid_data_out <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
                if (running && !tick) frame_cnt <= frame_cnt + CW'(1);
                else                  frame_cnt <= '0;
                valid_data_out <= tick;
                if (tick) begin
                    // An empty FIFO at the tick plays midscale silence.
                    data_out <= {24'd0, pop ? head_duty : 8'h80};
                    if (!pop && underrun_count != 16'hFFFF)
                        underrun_count <= underrun_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_sample_feeder.sv
// tb/tb_pwm_sample_feeder.sv - scoreboard bench for pwm_sample_feeder
module tb_pwm_sample_feeder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] data_out;
    logic        valid_data_out;
    logic [4:0]  fill;
    logic [15:0] underrun_count;
    logic        running;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         strobes = 0;
    int         prev_cyc = 0;
    bit         have_prev = 0;
    int         run_start = 0;
    logic [15:0] exp_under = '0;
    logic [31:0] exp_q[$];

    pwm_sample_feeder dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .data_out(data_out), .valid_data_out(valid_data_out),
        .fill(fill), .underrun_count(underrun_count), .running(running)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] to_duty(input logic [15:0] s);
        logic [7:0] hi;
        hi = s[15:8] ^ 8'h80;
        return {24'd0, hi};
    endfunction

    always @(negedge clk) begin
        if (valid_data_out === 1'b1) begin
            logic [31:0] e;
            strobes++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = 32'h80;
                if (exp_under != 16'hFFFF) exp_under = exp_under + 16'd1;
            end
            check("strobe_data", data_out, e);
            check("strobe_fill", 32'(fill), 32'(exp_q.size()));
            check("underrun_count", 32'(underrun_count), 32'(exp_under));
            if (have_prev) check("strobe_gap", 32'(cyc - prev_cyc), 32'd256);
            prev_cyc  = cyc;
            have_prev = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [15:0] d);
        bit done = 0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 1000 && !done; i++) begin
            if (s_ready) begin
                step();
                exp_q.push_back(to_duty(d));
                done = 1;
            end else begin
                step();
            end
        end
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_strobes(input int n);
        int target = strobes + n;
        int limit  = n * 256 + 600;
        for (int i = 0; i < limit && strobes < target; i++) step();
        if (strobes < target) check("strobe_timeout", 32'(strobes), 32'(target));
    endtask

    task automatic restart();
        enable = 1'b0;
        s_valid = 1'b0;
        step();
        exp_q.delete();
        have_prev = 0;
        enable = 1'b1;
        step();
    endtask

    initial begin
        int s0;
        rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) step();
        check("rst_running", 32'(running), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_valid", 32'(valid_data_out), 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_underrun", 32'(underrun_count), 32'd0);

        // priming and first-strobe latency
        rst_n = 1'b1; enable = 1'b1;
        step();
        check("prime_s_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 8; i++) push_sample(16'h0000);
        s_valid = 1'b0;
        check("prime_not_running", 32'(running), 32'd0);
        step();
        check("prime_running", 32'(running), 32'd1);
        run_start = cyc;
        wait_strobes(1);
        check("first_strobe_latency", 32'(prev_cyc - run_start), 32'd256);
        wait_strobes(1);

        // conversion of boundary samples
        restart();
        push_sample(16'h8000); push_sample(16'h7FFF);
        push_sample(16'h1234); push_sample(16'hFF00);
        for (int i = 0; i < 4; i++) push_sample(16'h0000);
        s_valid = 1'b0;
        wait_strobes(4);

        // full FIFO back-pressure
        restart();
        for (int i = 0; i < 16; i++) push_sample(16'(i * 16'h1111));
        s_data = 16'h4000;
        check("full_fill", 32'(fill), 32'd16);
        check("full_s_ready", 32'(s_ready), 32'd0);
        repeat (5) step();
        check("full_no_accept", 32'(fill), 32'd16);
        begin
            bit seen = 0;
            for (int i = 0; i < 400 && !seen; i++) begin
                @(negedge clk);
                if (valid_data_out) seen = 1;
            end
            if (!seen) check("full_tick_timeout", 32'd0, 32'd1);
        end
        check("after_pop_s_ready", 32'(s_ready), 32'd1);
        check("after_pop_fill", 32'(fill), 32'd15);
        step();
        exp_q.push_back(to_duty(16'h4000));
        s_valid = 1'b0;
        check("refill", 32'(fill), 32'd16);

        // underrun and saturation
        restart();
        for (int i = 0; i < 8; i++) push_sample(16'(16'h2000 + i));
        s_valid = 1'b0;
        wait_strobes(11);
        check("underrun_three", 32'(underrun_count), 32'd3);
        @(negedge clk);
        force dut.underrun_count = 16'hFFFF;
        exp_under = 16'hFFFF;
        step();
        release dut.underrun_count;
        wait_strobes(2);
        check("underrun_saturated", 32'(underrun_count), 32'hFFFF);

        // disable mid-frame with fill=5
        restart();
        for (int i = 0; i < 8; i++) push_sample(16'h0100);
        s_valid = 1'b0;
        wait_strobes(3);
        repeat (100) step();
        check("pre_disable_fill", 32'(fill), 32'd5);
        enable = 1'b0;
        step();
        exp_q.delete();
        have_prev = 0;
        check("dis_running", 32'(running), 32'd0);
        check("dis_fill", 32'(fill), 32'd0);
        check("dis_s_ready", 32'(s_ready), 32'd0);
        s0 = strobes;
        repeat (600) step();
        check("dis_no_strobe", 32'(strobes), 32'(s0));
        enable = 1'b1;
        step();
        check("reen_s_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 7; i++) push_sample(16'hC000);
        s_valid = 1'b0;
        repeat (300) step();
        check("reen_wait_prime", 32'(running), 32'd0);
        check("reen_no_strobe", 32'(strobes), 32'(s0));
        push_sample(16'hC000);
        s_valid = 1'b0;
        step();
        check("reen_running", 32'(running), 32'd1);
        run_start = cyc;

        // reset pulse on the cycle before a tick
        while (cyc < run_start + 254) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
        have_prev = 0;
        exp_under = '0;
        s0 = strobes;
        check("rst2_valid", 32'(valid_data_out), 32'd0);
        check("rst2_data", data_out, 32'd0);
        check("rst2_fill", 32'(fill), 32'd0);
        check("rst2_running", 32'(running), 32'd0);
        check("rst2_s_ready", 32'(s_ready), 32'd0);
        check("rst2_underrun", 32'(underrun_count), 32'd0);
        repeat (300) step();
        check("rst2_no_strobe", 32'(strobes), 32'(s0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
